uart_frame_tx: RTL and testbench

//  Parametrised UART frame transmitter. Replaces the fixed 40-bit ToPC byte sender with a generic one.

---
 rtl/uart_frame_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   Generic UART frame transmitter. On an accepted start the payload is
//   latched and sent as a sequence of 8N1 bytes on tx:
//     [optional header] payload bytes (LSB byte first) [optional checksum]
//   The checksum is the 8-bit wrap-around sum of the payload bytes only
//   (zero padding of the last byte included, header excluded).
//
// Parameters
//   FRAME_BITS    payload width in bits (>=1)
//   CLK_DIV       clk cycles per UART bit (>=2)
//   USE_HEADER    1: send HEADER before the payload
//   HEADER        header byte value
//   USE_CHECKSUM  1: append the payload checksum
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset, aborts any frame in progress
//   start       send request, only honoured in IDLE or DONE
//   frame_data  payload, latched on the accepting edge
//   busy        high while bytes are being shifted out
//   done        one-cycle pulse after the last stop bit
//   tx          UART line, idle high
//   byte_idx    index of the byte currently on the line (debug)
//   sta         FSM state encoding (debug)
//
// Handshake: start is a level sampled on every rising edge while the FSM is
// in IDLE or DONE; a sampled 1 there is the accept. While busy=1, start and
// frame_data are ignored and nothing is queued.

module uart_frame_tx #(
  parameter int          FRAME_BITS   = 40,
  parameter int          CLK_DIV      = 434,
  parameter int          USE_HEADER   = 1,
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter int          USE_CHECKSUM = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame_data,
  output logic                  busy,
  output logic                  done,
  output logic                  tx,
  output logic [7:0]            byte_idx,
  output logic [3:0]            sta
);

  localparam int FRAME_BYTES = (FRAME_BITS + 7) / 8;
  localparam int PAD_BITS    = FRAME_BYTES * 8;
  localparam int HDR_OFS     = (USE_HEADER != 0) ? 1 : 0;
  localparam int CHK_CNT     = (USE_CHECKSUM != 0) ? 1 : 0;
  localparam int N_TOTAL     = HDR_OFS + FRAME_BYTES + CHK_CNT;
  localparam int BAUD_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [7:0]        LAST_IDX  = 8'(N_TOTAL - 1);

  // NEXT is part of the documented encoding but is never resident: the
  // next-byte decision is made in the last STOP cycle, so a byte's start
  // bit follows its predecessor's stop bit without an idle cycle.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_DATA  = 4'd2,
    S_STOP  = 4'd3,
    S_NEXT  = 4'd4,
    S_DONE  = 4'd5
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          idx_q, idx_d;
  logic [PAD_BITS-1:0] frame_q, frame_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          sum_q, sum_d;

  logic                baud_end;
  logic [7:0]          pay_idx;
  logic [7:0]          pay_byte;
  logic [7:0]          cur_byte;
  logic                cur_is_payload;

  assign baud_end = (baud_q == BAUD_LAST);

  // Byte source for the current index. The checksum slot is only reached
  // after every payload byte has passed through the START->DATA load, so
  // sum_q is complete by then.
  always_comb begin
    pay_idx        = idx_q - 8'(HDR_OFS);
    pay_byte       = '0;
    cur_byte       = '0;
    cur_is_payload = 1'b0;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (pay_idx == 8'(i)) begin
        pay_byte = frame_q[i*8 +: 8];
      end
    end
    if ((HDR_OFS == 1) && (idx_q == 8'd0)) begin
      cur_byte = HEADER;
    end else if ((CHK_CNT == 1) && (idx_q == LAST_IDX)) begin
      cur_byte = sum_q;
    end else begin
      cur_byte       = pay_byte;
      cur_is_payload = 1'b1;
    end
  end

  // Next-state, datapath updates and outputs. Outputs are decoded from
  // flop outputs only, so they change right after the clock edge.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    shift_d = shift_q;
    sum_d   = sum_q;
    busy    = 1'b0;
    done    = 1'b0;
    tx      = 1'b1;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (start) begin
          state_d = S_START;
          frame_d = PAD_BITS'(frame_data);
          sum_d   = '0;
          idx_d   = '0;
          bit_d   = '0;
        end
      end

      S_START: begin
        busy = 1'b1;
        tx   = 1'b0;
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          shift_d = cur_byte;
          if (cur_is_payload) begin
            sum_d = sum_q + cur_byte;
          end
        end
      end

      S_DATA: begin
        busy = 1'b1;
        tx   = shift_q[bit_q];
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        busy = 1'b1;
        tx   = 1'b1;
        if (baud_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_START;
          end
        end
      end

      S_DONE: begin
        done   = 1'b1;
        baud_d = '0;
        // A start here chains the next frame without an idle cycle.
        if (start) begin
          state_d = S_START;
          frame_d = PAD_BITS'(frame_data);
          sum_d   = '0;
          idx_d   = '0;
          bit_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        // NEXT and unused encodings recover to IDLE with the line high.
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      shift_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      shift_q <= shift_d;
      sum_q   <= sum_d;
    end
  end

  assign byte_idx = idx_q;
  assign sta      = state_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx. Three instances share one clock and reset:
//   u0: defaults (40-bit payload, header, checksum)
//   u1: 12-bit payload, no header, checksum
//   u2: 8-bit payload, no header, no checksum
// All use CLK_DIV=4. The expected line waveform of every frame is built
// from a byte list (header, payload bytes, checksum) and compared cycle by
// cycle, while a mid-bit sampler recovers each byte.

module tb_uart_frame_tx;

  localparam int D = 4;

  logic        clk;
  logic        rst;
  logic        start0, start1, start2;
  logic [39:0] data0;
  logic [11:0] data1;
  logic [7:0]  data2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic        tx0, tx1, tx2;
  logic [7:0]  idx0, idx1, idx2;
  logic [3:0]  sta0, sta1, sta2;

  int          checks;
  int          failures;
  int          sel_m;
  logic        tx_m, busy_m, done_m;
  logic [7:0]  idx_m;
  logic [3:0]  sta_m;
  logic [7:0]  rx_got[16];

  typedef struct {
    logic [39:0] data;
    logic [7:0]  chk;
  } vec_t;

  uart_frame_tx #(.CLK_DIV(D)) u0 (
    .clk(clk), .rst(rst), .start(start0), .frame_data(data0),
    .busy(busy0), .done(done0), .tx(tx0), .byte_idx(idx0), .sta(sta0)
  );

  uart_frame_tx #(.FRAME_BITS(12), .CLK_DIV(D), .USE_HEADER(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .frame_data(data1),
    .busy(busy1), .done(done1), .tx(tx1), .byte_idx(idx1), .sta(sta1)
  );

  uart_frame_tx #(.FRAME_BITS(8), .CLK_DIV(D), .USE_HEADER(0), .USE_CHECKSUM(0)) u2 (
    .clk(clk), .rst(rst), .start(start2), .frame_data(data2),
    .busy(busy2), .done(done2), .tx(tx2), .byte_idx(idx2), .sta(sta2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (sel_m)
      1: begin tx_m = tx1; busy_m = busy1; done_m = done1; idx_m = idx1; sta_m = sta1; end
      2: begin tx_m = tx2; busy_m = busy2; done_m = done2; idx_m = idx2; sta_m = sta2; end
      default: begin tx_m = tx0; busy_m = busy0; done_m = done0; idx_m = idx0; sta_m = sta0; end
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic set_start(input int sel, input logic v, input logic [39:0] d);
    case (sel)
      1: begin start1 = v; if (v) data1 = d[11:0]; end
      2: begin start2 = v; if (v) data2 = d[7:0]; end
      default: begin start0 = v; if (v) data0 = d; end
    endcase
  endtask

  // Drives start for one cycle; returns at the negedge after the accepting edge.
  task automatic kick(input int sel, input logic [39:0] d);
    sel_m = sel;
    @(negedge clk);
    set_start(sel, 1'b1, d);
    @(posedge clk);
    @(negedge clk);
    set_start(sel, 1'b0, 40'd0);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b", name, got, exp);
    end
  endtask

  task automatic check_idle(input string name, input int sel);
    sel_m = sel;
    checks++;
    if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0 || sta_m !== 4'd0) begin
      failures++;
      $display("FAIL %s sel=%0d got tx=%0b busy=%0b done=%0b sta=%0d exp tx=1 busy=0 done=0 sta=0",
               name, sel, tx_m, busy_m, done_m, sta_m);
    end
  endtask

  // Scoreboard for one frame. Called at the first negedge after the
  // accepting edge. poke: pulse start with different data while busy.
  // chain: raise start in the DONE cycle with next_data.
  task automatic check_frame(input int sel, input logic [39:0] data, input bit poke,
                             input bit chain, input logic [39:0] next_data);
    logic [7:0]  exp_q[$];
    int          nbits, nbytes, cyc, bad_tx, bad_ctl, bad_dbg, exp_sta;
    logic [39:0] m;
    logic [7:0]  s, got;
    logic        exp_bit;
    sel_m  = sel;
    nbits  = (sel == 0) ? 40 : (sel == 1) ? 12 : 8;
    m      = (nbits == 40) ? data : (data & ((40'd1 << nbits) - 40'd1));
    nbytes = (nbits + 7) / 8;
    exp_q  = {};
    if (sel == 0) exp_q.push_back(8'hA5);
    s = 8'd0;
    for (int b = 0; b < nbytes; b++) begin
      exp_q.push_back(m[b*8 +: 8]);
      s = s + m[b*8 +: 8];
    end
    if (sel != 2) exp_q.push_back(s);

    cyc = 1;
    for (int k = 0; k < exp_q.size(); k++) begin
      bad_tx = 0; bad_ctl = 0; bad_dbg = 0; got = 8'd0;
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < D; c++) begin
          exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_q[k][j-1];
          exp_sta = (j == 0) ? 1 : (j == 9) ? 3 : 2;
          if (tx_m !== exp_bit) bad_tx++;
          if (busy_m !== 1'b1 || done_m !== 1'b0) bad_ctl++;
          if (sta_m !== 4'(exp_sta) || idx_m !== 8'(k)) bad_dbg++;
          if (c == D / 2 && j >= 1 && j <= 8) got[j-1] = tx_m;
          set_start(sel, poke && (cyc == 3 || cyc == 50 || cyc == 150), ~data);
          cyc++;
          @(negedge clk);
        end
      end
      rx_got[k] = got;
      checks++;
      if (got !== exp_q[k] || bad_tx != 0) begin
        failures++;
        $display("FAIL tx_byte sel=%0d k=%0d got=%02h exp=%02h bad_cycles=%0d", sel, k, got, exp_q[k], bad_tx);
      end
      checks++;
      if (bad_ctl != 0) begin
        failures++;
        $display("FAIL busy_done sel=%0d k=%0d bad_cycles=%0d exp=0", sel, k, bad_ctl);
      end
      checks++;
      if (bad_dbg != 0) begin
        failures++;
        $display("FAIL sta_idx sel=%0d k=%0d bad_cycles=%0d exp=0", sel, k, bad_dbg);
      end
    end

    // DONE cycle: cycle 1 + N_TOTAL*10*D after the accepting edge.
    checks++;
    if (done_m !== 1'b1 || busy_m !== 1'b0 || tx_m !== 1'b1 || sta_m !== 4'd5) begin
      failures++;
      $display("FAIL done_cycle sel=%0d cyc=%0d got done=%0b busy=%0b tx=%0b sta=%0d exp 1 0 1 5",
               sel, cyc, done_m, busy_m, tx_m, sta_m);
    end
    if (chain) begin
      set_start(sel, 1'b1, next_data);
      @(posedge clk);
      @(negedge clk);
      set_start(sel, 1'b0, 40'd0);
    end else begin
      @(negedge clk);
      check_idle("after_done", sel);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[5];
  int   done_seen;

  initial begin
    checks = 0; failures = 0; sel_m = 0;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    data0 = '0; data1 = '0; data2 = '0;

    vecs[0] = '{40'h123456789A, 8'hAE};
    vecs[1] = '{40'h0000000000, 8'h00};
    vecs[2] = '{40'hFFFFFFFFFF, 8'hFB};
    vecs[3] = '{40'h0102030405, 8'h0F};
    vecs[4] = '{40'h8080808080, 8'h80};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle("reset_state", i);
    checks++;
    if (idx0 !== 8'd0 || idx1 !== 8'd0 || idx2 !== 8'd0) begin
      failures++;
      $display("FAIL reset_idx got=%0d/%0d/%0d exp=0", idx0, idx1, idx2);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle("idle_no_start", i);

    // Table-driven frames on the default instance.
    for (int v = 0; v < 5; v++) begin
      kick(0, vecs[v].data);
      check_frame(0, vecs[v].data, 1'b0, 1'b0, 40'd0);
      checks++;
      if (rx_got[6] !== vecs[v].chk) begin
        failures++;
        $display("FAIL table_chk v=%0d got=%02h exp=%02h", v, rx_got[6], vecs[v].chk);
      end
    end

    // 12-bit payload without header: BC 0A C6.
    kick(1, 40'hABC);
    check_frame(1, 40'hABC, 1'b0, 1'b0, 40'd0);
    checks++;
    if (rx_got[0] !== 8'hBC || rx_got[1] !== 8'h0A || rx_got[2] !== 8'hC6) begin
      failures++;
      $display("FAIL bytes_12bit got=%02h %02h %02h exp=bc 0a c6", rx_got[0], rx_got[1], rx_got[2]);
    end

    // Single zero byte, bare 8N1.
    kick(2, 40'h00);
    check_frame(2, 40'h00, 1'b0, 1'b0, 40'd0);

    // Starts while busy are ignored; a start in DONE chains with no gap.
    kick(0, 40'hC0FFEE1234);
    check_frame(0, 40'hC0FFEE1234, 1'b1, 1'b1, 40'h5A5A00FF11);
    check_frame(0, 40'h5A5A00FF11, 1'b0, 1'b0, 40'd0);

    // Reset at cycle 150 of a frame aborts it without a done pulse.
    kick(0, 40'h0F1E2D3C4B);
    repeat (149) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("reset_abort", 0);
    check_bit("reset_abort_idx", idx0 == 8'd0, 1'b1);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (done0 === 1'b1 || busy0 === 1'b1 || tx0 !== 1'b1) done_seen++;
      @(negedge clk);
    end
    check_bit("no_done_after_abort", done_seen == 0, 1'b1);
    kick(0, 40'h0F1E2D3C4B);
    check_frame(0, 40'h0F1E2D3C4B, 1'b0, 1'b0, 40'd0);

    // Random payloads against the byte-list model.
    for (int r = 0; r < 12; r++) begin
      logic [39:0] d;
      int          sel;
      sel = r % 3;
      d   = {8'($urandom), 32'($urandom)};
      kick(sel, d);
      check_frame(sel, d, ($urandom_range(0, 1) == 1) && sel == 0, 1'b0, 40'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
